// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage.
//   NOP_INSTR     : word injected into IF/ID on a bubble or squash
//   PC_INC        : sequential PC increment
//   next_pc_sel_t : source select for the next-PC mux
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP,
    PC_CALL_RS1,
    PC_RET
  } next_pc_sel_t;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push, pop   : stack operations (never both in one cycle)
//   push_data   : return address to push
//   top         : current top entry, or EMPTY_TOP when the stack is empty
//   overflow    : one-cycle pulse after a push into a full stack
//   underflow   : one-cycle pulse after a pop from an empty stack
// A push into a full stack overwrites the oldest entry; the count saturates.
module return_address_stack #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter logic [31:0] EMPTY_TOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        overflow,
  output logic        underflow
);
  import fetch_pkg::*;

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  logic [31:0]     mem [RAS_DEPTH];
  logic [PtrW-1:0] ptrQ, ptrD, topIdx;
  logic [CntW-1:0] cntQ, cntD;
  logic            empty, full;
  logic            ovfQ, ovfD, unfQ, unfD;

  assign empty  = (cntQ == '0);
  assign full   = (cntQ == CntFull);
  // ptrQ points at the next free slot, so the top sits one below it (wrapping).
  assign topIdx = ptrQ - 1'b1;
  assign top    = empty ? EMPTY_TOP : mem[topIdx];

  always_comb begin
    ptrD = ptrQ;
    cntD = cntQ;
    ovfD = 1'b0;
    unfD = 1'b0;
    if (push) begin
      ptrD = ptrQ + 1'b1;
      if (full) begin
        ovfD = 1'b1;
      end else begin
        cntD = cntQ + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unfD = 1'b1;
      end else begin
        ptrD = ptrQ - 1'b1;
        cntD = cntQ - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptrQ <= '0;
      cntQ <= '0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      ptrQ <= ptrD;
      cntQ <= cntD;
      ovfQ <= ovfD;
      unfQ <= unfD;
    end
  end

  // Entry storage needs no reset: the count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptrQ] <= push_data;
    end
  end

  assign overflow  = ovfQ;
  assign underflow = unfQ;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection, IF/ID register and RAS.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   stall                 : freeze PC, IF/ID and RAS
//   imem_addr/imem_rdata  : combinational instruction-memory interface
//   branchAddress, jumpAddress, callRs1Address : redirect targets from decode
//   SIG_*                 : decode-stage control flags
//   instruction, PC4, id_valid : IF/ID register contents
//   ras_overflow, ras_underflow : one-cycle RAS error pulses
// Optional (macro IF_PERF_COUNTERS_EN): perf_fetched, perf_squashed counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] branchAddress,
  input  logic [31:0] jumpAddress,
  input  logic [31:0] callRs1Address,
  input  logic        SIG_EQ,
  input  logic        SIG_BEQ,
  input  logic        SIG_BNE,
  input  logic        SIG_Jump,
  input  logic        SIG_Call,
  input  logic        SIG_CALL_RS1,
  input  logic        SIG_RET,
  output logic [31:0] instruction,
  output logic [31:0] PC4,
  output logic        id_valid,
  output logic        ras_overflow,
  output logic        ras_underflow
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);
  import fetch_pkg::*;

  logic [31:0]  pcQ, pcD, pcPlus4;
  logic [31:0]  instrQ, instrD, pc4Q, pc4D;
  logic         validQ, validD;
  logic         ctrlEn, doRet, doCallRs1, doCall, doJump, brTaken;
  logic         redirect, rasPush, rasPop;
  logic [31:0]  rasTop;
  next_pc_sel_t pcSel;

  assign pcPlus4 = pcQ + PC_INC;

  // Decode flags only count when decode holds a real instruction that is
  // not being held by a hazard.
  assign ctrlEn    = validQ && !stall;
  assign doRet     = ctrlEn && SIG_RET;
  assign doCallRs1 = ctrlEn && !SIG_RET && SIG_CALL_RS1;
  assign doCall    = ctrlEn && !SIG_RET && !SIG_CALL_RS1 && SIG_Call;
  assign doJump    = ctrlEn && !SIG_RET && !SIG_CALL_RS1 && !SIG_Call && SIG_Jump;
  assign brTaken   = ctrlEn && !SIG_RET && !SIG_CALL_RS1 && !SIG_Call && !SIG_Jump &&
                     ((SIG_BEQ && SIG_EQ) || (SIG_BNE && !SIG_EQ));

  assign rasPush  = doCallRs1 || doCall;
  assign rasPop   = doRet;
  assign redirect = doRet || doCallRs1 || doCall || doJump || brTaken;

  always_comb begin
    pcSel = PC_SEQ;
    if (stall) begin
      pcSel = PC_HOLD;
    end else if (doRet) begin
      pcSel = PC_RET;
    end else if (doCallRs1) begin
      pcSel = PC_CALL_RS1;
    end else if (doCall || doJump) begin
      pcSel = PC_JUMP;
    end else if (brTaken) begin
      pcSel = PC_BRANCH;
    end
  end

  always_comb begin
    pcD = pcPlus4;
    unique case (pcSel)
      PC_HOLD:     pcD = pcQ;
      PC_SEQ:      pcD = pcPlus4;
      PC_BRANCH:   pcD = branchAddress;
      PC_JUMP:     pcD = jumpAddress;
      PC_CALL_RS1: pcD = callRs1Address;
      PC_RET:      pcD = rasTop;
      default:     pcD = pcPlus4;
    endcase
  end

  // IF/ID: hold on stall, squash the wrong-path word on redirect.
  always_comb begin
    instrD = imem_rdata;
    pc4D   = pcPlus4;
    validD = 1'b1;
    if (stall) begin
      instrD = instrQ;
      pc4D   = pc4Q;
      validD = validQ;
    end else if (redirect) begin
      instrD = NOP_INSTR;
      pc4D   = 32'h0;
      validD = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcQ    <= RESET_PC;
      instrQ <= NOP_INSTR;
      pc4Q   <= 32'h0;
      validQ <= 1'b0;
    end else begin
      pcQ    <= pcD;
      instrQ <= instrD;
      pc4Q   <= pc4D;
      validQ <= validD;
    end
  end

  // Returning from an empty stack restarts at the reset vector.
  return_address_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .EMPTY_TOP (RESET_PC)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (rasPush),
    .pop       (rasPop),
    .push_data (pc4Q),
    .top       (rasTop),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign imem_addr   = pcQ;
  assign instruction = instrQ;
  assign PC4         = pc4Q;
  assign id_valid    = validQ;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetchedQ, squashedQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchedQ  <= 32'h0;
      squashedQ <= 32'h0;
    end else begin
      if (!stall && !redirect) begin
        fetchedQ <= fetchedQ + 32'd1;
      end
      if (redirect) begin
        squashedQ <= squashedQ + 32'd1;
      end
    end
  end

  assign perf_fetched  = fetchedQ;
  assign perf_squashed = squashedQ;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a reference model predicts each
// cycle's outputs when inputs are driven, the prediction is queued, and it is
// popped and compared after the clock edge. Directed checks pin the key
// addresses and pulse counts from the fetch/redirect/RAS scenarios.
module tb_instruction_fetch;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam int          RasDepth = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] branchAddress, jumpAddress, callRs1Address;
  logic        SIG_EQ, SIG_BEQ, SIG_BNE, SIG_Jump, SIG_Call, SIG_CALL_RS1, SIG_RET;
  logic [31:0] instruction, PC4;
  logic        id_valid, ras_overflow, ras_underflow;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  instruction_fetch #(
    .RESET_PC  (ResetPc),
    .RAS_DEPTH (RasDepth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .branchAddress  (branchAddress),
    .jumpAddress    (jumpAddress),
    .callRs1Address (callRs1Address),
    .SIG_EQ         (SIG_EQ),
    .SIG_BEQ        (SIG_BEQ),
    .SIG_BNE        (SIG_BNE),
    .SIG_Jump       (SIG_Jump),
    .SIG_Call       (SIG_Call),
    .SIG_CALL_RS1   (SIG_CALL_RS1),
    .SIG_RET        (SIG_RET),
    .instruction    (instruction),
    .PC4            (PC4),
    .id_valid       (id_valid),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        ovf;
    logic        unf;
    logic [31:0] fetched;
    logic [31:0] squashed;
  } exp_t;

  exp_t expQ[$];

  int errCount = 0;
  int chkCount = 0;
  int ovfSeen  = 0;
  int unfSeen  = 0;

  // Reference model state
  logic [31:0] mPc, mInstr, mPc4, mFetched, mSquashed;
  logic        mValid, mOvf, mUnf;
  logic [31:0] mRas [RasDepth];
  int          mPtr, mCnt;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPc = ResetPc; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    mOvf = 1'b0; mUnf = 1'b0; mPtr = 0; mCnt = 0;
    mFetched = 32'h0; mSquashed = 32'h0;
  endtask

  task automatic clearCtrl();
    stall = 1'b0; SIG_EQ = 1'b0; SIG_BEQ = 1'b0; SIG_BNE = 1'b0; SIG_Jump = 1'b0;
    SIG_Call = 1'b0; SIG_CALL_RS1 = 1'b0; SIG_RET = 1'b0;
  endtask

  // One clock: predict, queue, clock, pop and compare.
  task automatic step();
    exp_t        e, got;
    logic        en, redir, doPush, doPop;
    logic [31:0] seq, nPc;
    seq = mPc + 32'd4;
    en = mValid && !stall;
    redir = 1'b0; doPush = 1'b0; doPop = 1'b0; nPc = seq;
    if (stall) nPc = mPc;
    else if (en && SIG_RET) begin
      redir = 1'b1; doPop = 1'b1;
      nPc = (mCnt == 0) ? ResetPc : mRas[(mPtr + RasDepth - 1) % RasDepth];
    end else if (en && SIG_CALL_RS1) begin
      redir = 1'b1; doPush = 1'b1; nPc = callRs1Address;
    end else if (en && SIG_Call) begin
      redir = 1'b1; doPush = 1'b1; nPc = jumpAddress;
    end else if (en && SIG_Jump) begin
      redir = 1'b1; nPc = jumpAddress;
    end else if (en && ((SIG_BEQ && SIG_EQ) || (SIG_BNE && !SIG_EQ))) begin
      redir = 1'b1; nPc = branchAddress;
    end
    mOvf = doPush && (mCnt == RasDepth);
    mUnf = doPop && (mCnt == 0);
    if (doPush) begin
      mRas[mPtr] = mPc4;
      mPtr = (mPtr + 1) % RasDepth;
      if (mCnt < RasDepth) mCnt++;
    end else if (doPop && mCnt > 0) begin
      mPtr = (mPtr + RasDepth - 1) % RasDepth;
      mCnt--;
    end
    if (!stall) begin
      if (redir) begin
        mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mSquashed++;
      end else begin
        mInstr = memWord(mPc); mPc4 = seq; mValid = 1'b1; mFetched++;
      end
    end
    mPc = nPc;
    e = '{pc: mPc, instr: mInstr, pc4: mPc4, valid: mValid, ovf: mOvf, unf: mUnf,
          fetched: mFetched, squashed: mSquashed};
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkEq("imem_addr", imem_addr, got.pc);
    checkEq("instruction", instruction, got.instr);
    checkEq("PC4", PC4, got.pc4);
    checkEq("id_valid", {31'h0, id_valid}, {31'h0, got.valid});
    checkEq("ras_overflow", {31'h0, ras_overflow}, {31'h0, got.ovf});
    checkEq("ras_underflow", {31'h0, ras_underflow}, {31'h0, got.unf});
`ifdef IF_PERF_COUNTERS_EN
    checkEq("perf_fetched", perf_fetched, got.fetched);
    checkEq("perf_squashed", perf_squashed, got.squashed);
`endif
    if (ras_overflow) ovfSeen++;
    if (ras_underflow) unfSeen++;
  endtask

  task automatic checkCleared(input string tag);
    checkEq({tag, "_addr"}, imem_addr, ResetPc);
    checkEq({tag, "_instr"}, instruction, 32'h0);
    checkEq({tag, "_pc4"}, PC4, 32'h0);
    checkEq({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
    checkEq({tag, "_ovf"}, {31'h0, ras_overflow}, 32'h0);
    checkEq({tag, "_unf"}, {31'h0, ras_underflow}, 32'h0);
`ifdef IF_PERF_COUNTERS_EN
    checkEq({tag, "_fetched"}, perf_fetched, 32'h0);
    checkEq({tag, "_squashed"}, perf_squashed, 32'h0);
`endif
  endtask

  initial begin
    clearCtrl();
    branchAddress = 32'h0; jumpAddress = 32'h0; callRs1Address = 32'h0;
    reset = 1'b1;
    modelReset();
    #2;
    checkCleared("reset");
    #1 reset = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      step();
      checkEq("seqPc4", PC4, 32'(4 * i));
      checkEq("seqInstr", instruction, memWord(32'(4 * (i - 1))));
    end

    // Taken BEQ: one bubble, then fetch from target
    SIG_BEQ = 1'b1; SIG_EQ = 1'b1; branchAddress = 32'h40;
    step();
    checkEq("beqTarget", imem_addr, 32'h40);
    checkEq("beqBubble", {31'h0, id_valid}, 32'h0);
    clearCtrl();
    step();
    checkEq("beqFetch", instruction, memWord(32'h40));
    // Not-taken BEQ: no bubble
    SIG_BEQ = 1'b1; SIG_EQ = 1'b0;
    step();
    checkEq("beqNtPc", imem_addr, 32'h48);
    checkEq("beqNtValid", {31'h0, id_valid}, 32'h1);
    clearCtrl();

    // Steer so that decode holds PC4 = 0x20, then call/nested call/returns
    SIG_Jump = 1'b1; jumpAddress = 32'h1C;
    step(); clearCtrl(); step();
    checkEq("callSitePc4", PC4, 32'h20);
    SIG_Call = 1'b1; jumpAddress = 32'h100;
    step(); clearCtrl();
    checkEq("callTarget", imem_addr, 32'h100);
    step();
    SIG_CALL_RS1 = 1'b1; callRs1Address = 32'h200;
    step(); clearCtrl();
    checkEq("callRs1Target", imem_addr, 32'h200);
    step();
    SIG_RET = 1'b1;
    step(); clearCtrl();
    checkEq("ret1", imem_addr, 32'h104);
    step();
    SIG_RET = 1'b1;
    step(); clearCtrl();
    checkEq("ret2", imem_addr, 32'h20);
    step();

    // RAS overflow then underflow
    ovfSeen = 0; unfSeen = 0;
    for (int i = 0; i <= RasDepth; i++) begin
      SIG_Call = 1'b1; jumpAddress = 32'h300 + 32'(i * 16);
      step(); clearCtrl(); step();
    end
    checkEq("ovfPulses", 32'(ovfSeen), 32'd1);
    for (int i = 0; i <= RasDepth; i++) begin
      SIG_RET = 1'b1;
      step(); clearCtrl();
      if (i == RasDepth) checkEq("underflowPc", imem_addr, ResetPc);
      step();
    end
    checkEq("unfPulses", 32'(unfSeen), 32'd1);

    // Stall with a pending jump: hold, then take the jump once
    stall = 1'b1; SIG_Jump = 1'b1; jumpAddress = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      checkEq("stallPc", imem_addr, 32'h4);
    end
    stall = 1'b0;
    step(); SIG_Jump = 1'b0;
    checkEq("jumpAfterStall", imem_addr, 32'h500);
    step(); step();
    checkEq("jumpOnce", imem_addr, 32'h508);

    // PC4 wraps at the top of the address space
    SIG_Jump = 1'b1; jumpAddress = 32'hFFFF_FFFC;
    step(); clearCtrl(); step();
    checkEq("wrapPc4", PC4, 32'h0);
    checkEq("wrapPc", imem_addr, 32'h0);
    step(); step();

    // Asynchronous reset mid-run
    #2 reset = 1'b1;
    #1 checkCleared("midReset");
    #1 reset = 1'b0;
    modelReset();
    step();
    checkEq("resumeInstr", instruction, memWord(ResetPc));
    checkEq("resumePc", imem_addr, ResetPc + 32'd4);

    checkEq("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule
